// File: rtl/uart_rx_cmd_if.sv
// Serial command link between the host UART line and the game's command input.
// master: the receiver side; slave: line driver and byte consumer.
interface uart_rx_cmd_if;
    logic       rx;
    logic [7:0] dataRX;
    logic       WR_RX;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        input  rx,
        output dataRX,
        output WR_RX,
        output frame_err,
        output rx_busy
    );

    modport slave (
        output rx,
        input  dataRX,
        input  WR_RX,
        input  frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx_cmd.sv
// 8N1 UART receiver for the snake game command input.
// Emits each well-framed byte with a one-cycle WR_RX strobe on clk.
module uart_rx_cmd #(
    parameter int CLK_HZ = 25000000,
    parameter int BAUD   = 115200
) (
    input logic           clk,
    input logic           rstn,
    uart_rx_cmd_if.master bus
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] C_HALF = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] C_BIT  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic [1:0]    r_sync;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shreg;
    logic [7:0]    r_data;
    logic          r_wr;
    logic          r_ferr;
    logic          r_busy;
    logic          w_rx_s;

    assign w_rx_s = r_sync[1];

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], bus.rx};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_data    <= '0;
            r_wr      <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_wr   <= 1'b0;
            r_ferr <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == C_HALF) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == C_BIT) begin
                        r_cnt   <= '0;
                        r_shreg <= {w_rx_s, r_shreg[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == C_BIT) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_data  <= r_shreg;
                            r_wr    <= 1'b1;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    // A held-low line must not turn into a stream of 0x00 bytes.
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dataRX    = r_data;
    assign bus.WR_RX     = r_wr;
    assign bus.frame_err = r_ferr;
    assign bus.rx_busy   = r_busy;
endmodule

// File: tb/tb_uart_rx_cmd.sv
// Self-checking bench for uart_rx_cmd: serial frames in, expected byte events out.
// A queue of predicted events is matched against every strobe the receiver issues.
module tb_uart_rx_cmd;
    localparam int CPB  = 217;
    localparam int HALF = 108;
    localparam int LAT  = 2 + HALF + 9 * CPB;

    typedef struct {
        longint     cyc;
        bit         err;
        logic [7:0] d;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    uart_rx_cmd_if bus();

    uart_rx_cmd #(.CLK_HZ(25000000), .BAUD(115200)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #20 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         n_wr  = 0;
    int         n_fe  = 0;
    longint     cyc     = 0;
    longint     last_wr = -1;
    longint     last_fe = -1;
    longint     prev_p  = -1;
    logic [7:0] model_d = 8'h00;
    exp_t       q[$];
    exp_t       e_cur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    // Every cycle: strobes must match the predicted event queue, dataRX the model.
    always @(negedge clk) begin
        if (!rstn) begin
            model_d = 8'h00;
            prev_p  = -1;
            chk("reset_outputs",
                32'({bus.dataRX, bus.WR_RX, bus.frame_err, bus.rx_busy}), 0);
        end else begin
            if (bus.WR_RX || bus.frame_err) begin
                chk("wr_ferr_exclusive", 32'(bus.WR_RX && bus.frame_err), 0);
                if (q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    e_cur = q.pop_front();
                    chk("pulse_kind", 32'(bus.frame_err), 32'(e_cur.err));
                    chk("pulse_time",
                        32'(cyc >= e_cur.cyc - 2 && cyc <= e_cur.cyc + 2), 1);
                    if (!e_cur.err) model_d = e_cur.d;
                end
                if (prev_p >= 0)
                    chk("pulse_spacing", 32'(cyc - prev_p >= 8 * CPB), 1);
                prev_p = cyc;
                if (bus.WR_RX) begin
                    last_wr = cyc;
                    n_wr++;
                end
                if (bus.frame_err) begin
                    last_fe = cyc;
                    n_fe++;
                end
            end else if (q.size() != 0 && cyc > q[0].cyc + 2) begin
                chk("missing_pulse", 1, 0);
                void'(q.pop_front());
            end
            chk("dataRX", 32'(bus.dataRX), 32'(model_d));
        end
    end

    task automatic hold(logic v, int n);
        bus.rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [7:0] d, int p, bit stop_ok);
        exp_t e;
        e.cyc = cyc + LAT;
        e.err = !stop_ok;
        e.d   = d;
        q.push_back(e);
        hold(1'b0, p);
        for (int i = 0; i < 8; i++) hold(d[i], p);
        hold(stop_ok, p);
    endtask

    longint     k;
    longint     w1;
    int         busy_cnt;
    int         p;
    bit         ok;
    logic [7:0] b44;
    logic [7:0] rd;

    initial begin
        bus.rx = 1'b1;
        #5 rstn = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_dataRX", 32'(bus.dataRX), 0);
        chk("rst_busy", 32'(bus.rx_busy), 0);
        rstn = 1'b1;
        hold(1'b1, 20);

        k = cyc;
        send(8'h41, CPB, 1'b1);
        hold(1'b1, 50);
        chk("t1_latency", 32'(last_wr - k >= 2061 && last_wr - k <= 2066), 1);
        chk("t1_data", 32'(bus.dataRX), 32'h41);
        chk("t1_no_ferr", n_fe, 0);

        send(8'h43, CPB, 1'b1);
        w1 = last_wr;
        send(8'h44, CPB, 1'b1);
        hold(1'b1, 100);
        chk("t2_pulse_gap", 32'(last_wr - w1), 2170);
        chk("t2_data", 32'(bus.dataRX), 32'h44);
        chk("t2_wr_count", n_wr, 3);

        busy_cnt = 0;
        bus.rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            busy_cnt += int'(bus.rx_busy);
        end
        bus.rx = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            busy_cnt += int'(bus.rx_busy);
        end
        chk("t3_busy_len", 32'(busy_cnt >= 100 && busy_cnt <= 115), 1);
        chk("t3_busy_idle", 32'(bus.rx_busy), 0);
        chk("t3_no_pulse", n_wr + n_fe, 3);

        send(8'h42, CPB, 1'b0);
        hold(1'b0, 3 * CPB);
        chk("t4_break_busy", 32'(bus.rx_busy), 1);
        chk("t4_ferr_count", n_fe, 1);
        chk("t4_data_kept", 32'(bus.dataRX), 32'h44);
        hold(1'b1, 5);
        chk("t4_break_exit", 32'(bus.rx_busy), 0);
        hold(1'b1, 20);
        send(8'h41, CPB, 1'b1);
        hold(1'b1, 50);
        chk("t4_after_data", 32'(bus.dataRX), 32'h41);
        chk("t4_wr_count", n_wr, 4);

        b44 = 8'h44;
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(b44[i], CPB);
        hold(b44[4], CPB / 2);
        rstn = 1'b0;
        bus.rx = 1'b1;
        #1;
        chk("t5_async_rst",
            32'({bus.dataRX, bus.WR_RX, bus.frame_err, bus.rx_busy}), 0);
        hold(1'b1, 10);
        rstn = 1'b1;
        hold(1'b1, 20);
        send(8'h41, CPB, 1'b1);
        hold(1'b1, 50);
        chk("t5_data", 32'(bus.dataRX), 32'h41);
        chk("t5_wr_count", n_wr, 5);

        send(8'hFF, 224, 1'b1);
        send(8'h00, 224, 1'b1);
        hold(1'b1, 100);
        chk("t6_data", 32'(bus.dataRX), 32'h00);
        chk("t6_no_ferr", n_fe, 1);
        chk("t6_wr_count", n_wr, 7);

        for (int n = 0; n < 14; n++) begin
            p  = int'($urandom_range(213, 221));
            rd = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send(rd, p, ok);
            if (!ok) hold(1'b0, int'($urandom_range(0, 400)));
            hold(1'b1, ok ? int'($urandom_range(0, 300))
                          : int'($urandom_range(5, 300)));
        end

        for (int i = 0; i < 3000 && q.size() != 0; i++) hold(1'b1, 1);
        hold(1'b1, 5);
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
